// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM slot sequencer and its channel finder.
package tdm_pkg;

    localparam int CH_W   = 3;
    localparam int NUM_CH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_e;

    // Slot counter needs at least one bit even when SLOT_CYCLES is 1.
    function automatic int cntWidth(input int slotCycles);
        int w;
        w = $clog2(slotCycles);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [CH_W-1:0] lowestSet(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tdm_slot_sequencer_next_ch_find.sv
// Combinational search of a channel mask: next set bit above cur, and the lowest set bit.
module next_ch_find
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_i,
    output logic [CH_W-1:0]   nxt_o,
    output logic              found_o,
    output logic [CH_W-1:0]   first_o
);

    // Scanning downward lets the last hit be the lowest qualifying index.
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        first_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                first_o = CH_W'(i);
            end
            if (mask_i[i] && (i > int'(cur_i))) begin
                nxt_o   = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_slot_sequencer.sv
// Frame sequencer driving sel/en/data of an 8-way 1-bit demux, one slot per enabled channel.
module tdm_slot_sequencer
    import tdm_pkg::CH_W;
    import tdm_pkg::state_e;
    import tdm_pkg::IDLE;
    import tdm_pkg::SLOT;
    import tdm_pkg::cntWidth;
    import tdm_pkg::lowestSet;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int NUM_CH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              din_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    output logic [CH_W-1:0]   sel_o,
    output logic              en_o,
    output logic              dout_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [7:0]        frame_cnt_o,
    output logic              cfg_err_o
);

    localparam int CNT_W = cntWidth(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

    state_e            state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CNT_W-1:0]  slotCnt_q;
    logic              stopReq_q;
    logic [CH_W-1:0]   sel_q;
    logic              en_q;
    logic              dout_q;
    logic              busy_q;
    logic              frameDone_q;
    logic [7:0]        frameCnt_q;
    logic              cfgErr_q;

    logic [NUM_CH-1:0] findMask;
    logic [CH_W-1:0]   nxtCh;
    logic              nxtFound;
    logic [CH_W-1:0]   firstCh;
    logic              stopNow;

    // In IDLE the finder looks at the live mask to pick the first slot; otherwise at the latched frame mask.
    assign findMask = (state_q == IDLE) ? ch_mask_i : mask_q;
    assign stopNow  = stopReq_q | stop_i;

    next_ch_find u_find (
        .mask_i  (findMask),
        .cur_i   (sel_q),
        .nxt_o   (nxtCh),
        .found_o (nxtFound),
        .first_o (firstCh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            slotCnt_q   <= '0;
            stopReq_q   <= 1'b0;
            sel_q       <= '0;
            en_q        <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
            cfgErr_q    <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            cfgErr_q    <= 1'b0;
            dout_q      <= din_i;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (ch_mask_i != '0) begin
                            mask_q    <= ch_mask_i;
                            sel_q     <= firstCh;
                            en_q      <= 1'b1;
                            busy_q    <= 1'b1;
                            slotCnt_q <= '0;
                            state_q   <= SLOT;
                        end else begin
                            cfgErr_q <= 1'b1;
                        end
                    end
                end
                SLOT: begin
                    if (stop_i) begin
                        stopReq_q <= 1'b1;
                    end
                    if (slotCnt_q == LAST_CNT) begin
                        slotCnt_q <= '0;
                        if (nxtFound) begin
                            sel_q <= nxtCh;
                        end else begin
                            // Frame boundary: a pending stop beats reloading the mask.
                            frameDone_q <= 1'b1;
                            frameCnt_q  <= frameCnt_q + 8'd1;
                            if (stopNow) begin
                                en_q      <= 1'b0;
                                busy_q    <= 1'b0;
                                stopReq_q <= 1'b0;
                                state_q   <= IDLE;
                            end else if (ch_mask_i == '0) begin
                                cfgErr_q  <= 1'b1;
                                en_q      <= 1'b0;
                                busy_q    <= 1'b0;
                                stopReq_q <= 1'b0;
                                state_q   <= IDLE;
                            end else begin
                                mask_q <= ch_mask_i;
                                sel_q  <= lowestSet(ch_mask_i);
                            end
                        end
                    end else begin
                        slotCnt_q <= slotCnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_o        = sel_q;
    assign en_o         = en_q;
    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frameDone_q;
    assign frame_cnt_o  = frameCnt_q;
    assign cfg_err_o    = cfgErr_q;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Directed self-checking bench: a SLOT_CYCLES=4 instance for framing/control and a SLOT_CYCLES=1 instance for data alignment.
module tb_tdm_slot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       stop = 1'b0;
    logic       din = 1'b0;
    logic [7:0] chMask = 8'h00;

    logic [2:0] sel,  sel1;
    logic       en,   en1;
    logic       dout, dout1;
    logic       busy, busy1;
    logic       fDone, fDone1;
    logic [7:0] fCnt, fCnt1;
    logic       cErr, cErr1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_slot_sequencer #(.SLOT_CYCLES(4), .NUM_CH(8)) dut (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .din_i(din),
        .ch_mask_i(chMask), .sel_o(sel), .en_o(en), .dout_o(dout), .busy_o(busy),
        .frame_done_o(fDone), .frame_cnt_o(fCnt), .cfg_err_o(cErr)
    );

    tdm_slot_sequencer #(.SLOT_CYCLES(1), .NUM_CH(8)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .stop_i(stop), .din_i(din),
        .ch_mask_i(chMask), .sel_o(sel1), .en_o(en1), .dout_o(dout1), .busy_o(busy1),
        .frame_done_o(fDone1), .frame_cnt_o(fCnt1), .cfg_err_o(cErr1)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; stop = 1'b0; din = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (sel !== 3'd0)  begin errors++; $display("[TB] FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (en !== 1'b0)   begin errors++; $display("[TB] FAIL reset_en got=%b exp=0", en); end
        checks++; if (dout !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout got=%b exp=0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_fdone got=%b exp=0", fDone); end
        checks++; if (fCnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_fcnt got=%0d exp=0", fCnt); end
        checks++; if (cErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_cerr got=%b exp=0", cErr); end
        checks++; if (en1 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_en1 got=%b exp=0", en1); end
        rst = 1'b0;
    endtask

    // All eight channels, four cycles each; a stop mid-frame ends the run after this single frame.
    task automatic test_full_frame();
        doReset();
        chMask = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++; if (sel !== 3'(k / 4)) begin errors++; $display("[TB] FAIL full_sel k=%0d got=%0d exp=%0d", k, sel, k / 4); end
            checks++; if (en !== 1'b1)       begin errors++; $display("[TB] FAIL full_en k=%0d got=%b exp=1", k, en); end
            checks++; if (fDone !== 1'b0)    begin errors++; $display("[TB] FAIL full_fdone k=%0d got=%b exp=0", k, fDone); end
            stop = (k == 5);
            tick();
        end
        stop = 1'b0;
        checks++; if (fDone !== 1'b1) begin errors++; $display("[TB] FAIL full_end_fdone got=%b exp=1", fDone); end
        checks++; if (fCnt !== 8'd1)  begin errors++; $display("[TB] FAIL full_end_fcnt got=%0d exp=1", fCnt); end
        checks++; if (en !== 1'b0)    begin errors++; $display("[TB] FAIL full_end_en got=%b exp=0", en); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL full_end_busy got=%b exp=0", busy); end
        checks++; if (sel !== 3'd7)   begin errors++; $display("[TB] FAIL full_end_sel got=%0d exp=7", sel); end
        tick();
        checks++; if (fDone !== 1'b0) begin errors++; $display("[TB] FAIL full_pulse_width got=%b exp=0", fDone); end
    endtask

    // Sparse mask 2,5,7 repeated with no gap; start while busy must be ignored.
    task automatic test_continuous();
        logic [2:0] seq [3];
        seq[0] = 3'd2; seq[1] = 3'd5; seq[2] = 3'd7;
        doReset();
        chMask = 8'b1010_0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 36; k++) begin
            checks++; if (sel !== seq[(k / 4) % 3]) begin errors++; $display("[TB] FAIL cont_sel k=%0d got=%0d exp=%0d", k, sel, seq[(k / 4) % 3]); end
            checks++; if (en !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL cont_en k=%0d got=%b%b exp=11", k, en, busy); end
            checks++; if (fDone !== (k > 0 && k % 12 == 0)) begin errors++; $display("[TB] FAIL cont_fdone k=%0d got=%b", k, fDone); end
            start = (k == 7);
            tick();
        end
        start = 1'b0;
        checks++; if (fDone !== 1'b1) begin errors++; $display("[TB] FAIL cont_fdone3 got=%b exp=1", fDone); end
        checks++; if (fCnt !== 8'd3)  begin errors++; $display("[TB] FAIL cont_fcnt got=%0d exp=3", fCnt); end
        checks++; if (sel !== 3'd2 || en !== 1'b1) begin errors++; $display("[TB] FAIL cont_wrap sel=%0d en=%b exp sel=2 en=1", sel, en); end
    endtask

    // Stop during frame 2 lets frame 2 finish, then idles; stop in IDLE is ignored.
    task automatic test_stop();
        doReset();
        chMask = 8'b1010_0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            checks++; if (en !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_run k=%0d got=%b%b exp=11", k, en, busy); end
            stop = (k == 15);
            tick();
        end
        stop = 1'b0;
        checks++; if (fDone !== 1'b1) begin errors++; $display("[TB] FAIL stop_fdone got=%b exp=1", fDone); end
        checks++; if (fCnt !== 8'd2)  begin errors++; $display("[TB] FAIL stop_fcnt got=%0d exp=2", fCnt); end
        checks++; if (en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_idle got=%b%b exp=00", en, busy); end
        checks++; if (sel !== 3'd7)   begin errors++; $display("[TB] FAIL stop_sel_hold got=%0d exp=7", sel); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (fDone !== 1'b0 || en !== 1'b0) begin errors++; $display("[TB] FAIL stop_stay_idle fd=%b en=%b exp=00", fDone, en); end
        chMask = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++; if (fDone !== 1'b1 || en !== 1'b1) begin errors++; $display("[TB] FAIL stop_idle_ignored fd=%b en=%b exp=11", fDone, en); end
        checks++; if (fCnt !== 8'd3) begin errors++; $display("[TB] FAIL stop_fcnt_after got=%0d exp=3", fCnt); end
    endtask

    task automatic test_cfg_err();
        doReset();
        chMask = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (cErr !== 1'b1) begin errors++; $display("[TB] FAIL cerr_start got=%b exp=1", cErr); end
        checks++; if (en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL cerr_start_idle got=%b%b exp=00", en, busy); end
        tick();
        checks++; if (cErr !== 1'b0) begin errors++; $display("[TB] FAIL cerr_width got=%b exp=0", cErr); end
        chMask = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (en !== 1'b1 || sel !== 3'(k / 4)) begin errors++; $display("[TB] FAIL cerr_run k=%0d en=%b sel=%0d exp en=1 sel=%0d", k, en, sel, k / 4); end
            if (k == 2) chMask = 8'h00;
            tick();
        end
        checks++; if (fDone !== 1'b1 || cErr !== 1'b1) begin errors++; $display("[TB] FAIL cerr_reload fd=%b ce=%b exp=11", fDone, cErr); end
        checks++; if (en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL cerr_reload_idle got=%b%b exp=00", en, busy); end
        checks++; if (fCnt !== 8'd1) begin errors++; $display("[TB] FAIL cerr_fcnt got=%0d exp=1", fCnt); end
        tick();
        checks++; if (cErr !== 1'b0) begin errors++; $display("[TB] FAIL cerr_reload_width got=%b exp=0", cErr); end
    endtask

    task automatic test_reset_mid();
        doReset();
        chMask = 8'h01;
        din = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        checks++; if (fCnt !== 8'd2) begin errors++; $display("[TB] FAIL rmid_pre_fcnt got=%0d exp=2", fCnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din = 1'b0;
        checks++; if ({sel, en, dout, busy, fDone, cErr} !== 8'd0) begin errors++; $display("[TB] FAIL rmid_outs got=%b exp=0", {sel, en, dout, busy, fDone, cErr}); end
        checks++; if (fCnt !== 8'd0) begin errors++; $display("[TB] FAIL rmid_fcnt got=%0d exp=0", fCnt); end
        chMask = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (en !== 1'b1 || busy !== 1'b1 || sel !== 3'd4) begin errors++; $display("[TB] FAIL rmid_restart en=%b busy=%b sel=%0d exp 1 1 4", en, busy, sel); end
    endtask

    // dout registered alongside sel: the bit presented before each edge appears with that edge's channel.
    task automatic test_slot1_data();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        doReset();
        chMask = 8'h0F;
        start1 = 1'b1;
        din = pat[0];
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (sel1 !== 3'(k) || en1 !== 1'b1) begin errors++; $display("[TB] FAIL s1_sel k=%0d sel=%0d en=%b exp sel=%0d en=1", k, sel1, en1, k); end
            checks++; if (dout1 !== pat[k]) begin errors++; $display("[TB] FAIL s1_dout k=%0d got=%b exp=%b", k, dout1, pat[k]); end
            checks++; if (fDone1 !== (k == 0 ? 1'b0 : 1'b0)) begin errors++; $display("[TB] FAIL s1_fdone k=%0d got=%b exp=0", k, fDone1); end
            din = (k < 3) ? pat[k + 1] : 1'b0;
            tick();
        end
        checks++; if (fDone1 !== 1'b1 || sel1 !== 3'd0 || en1 !== 1'b1) begin errors++; $display("[TB] FAIL s1_wrap fd=%b sel=%0d en=%b exp 1 0 1", fDone1, sel1, en1); end
        checks++; if (fCnt1 !== 8'd1) begin errors++; $display("[TB] FAIL s1_fcnt got=%0d exp=1", fCnt1); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_continuous();
        test_stop();
        test_cfg_err();
        test_reset_mid();
        test_slot1_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
